// File: rtl/eth_helper_pkg.sv
// Shared constants for the Ethernet payload packer.
// Lane count, index widths, send_size encodings, counter widths.
package eth_helper_pkg;

  localparam int LANES      = 4;
  localparam int LANE_IDX_W = 2;
  localparam int CNT_W      = LANE_IDX_W + 1;
  localparam int FRAMES_W   = 16;

  localparam logic [1:0] SEND_SIZE_8B  = 2'b00;
  localparam logic [1:0] SEND_SIZE_16B = 2'b01;
  localparam logic [1:0] SEND_SIZE_24B = 2'b10;
  localparam logic [1:0] SEND_SIZE_32B = 2'b11;

  function automatic logic [1:0] lanes_to_size(
    input logic [CNT_W-1:0] n
  );
    logic [CNT_W-1:0] m;
    m = n - 1'b1;
    return m[1:0];
  endfunction

endpackage

// File: rtl/eth_flush_timer.sv
// Idle timer that closes a partially filled slot.
// Ports: ACLK, ARESETN, clr, en in; expire out (one cycle, never when TIMEOUT=0).
module eth_flush_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic ARMED = (TIMEOUT != 0);

  logic [CW-1:0] cnt_q;

  // Saturates at LAST so a stalled slot never wraps back to zero.
  always_ff @(posedge ACLK) begin
    if (!ARESETN || clr)
      cnt_q <= '0;
    else if (en && cnt_q != LAST)
      cnt_q <= cnt_q + 1'b1;
  end

  assign expire = ARMED & en & (cnt_q == LAST);

endmodule

// File: rtl/eth_payload_packer.sv
// Packs narrow AXI-Stream beats into multi-lane payload words.
// Ports: ACLK/ARESETN, S_AXIS_* sink, send_* source, frames_sent count.
module eth_payload_packer
  import eth_helper_pkg::*;
#(
  parameter int RAW_DATA_WIDTH = 256,
  parameter int LANE_WIDTH     = 64,
  parameter int FLUSH_TIMEOUT  = 1024
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [LANE_WIDTH-1:0]     S_AXIS_tdata,
  input  logic                      S_AXIS_tvalid,
  input  logic                      S_AXIS_tlast,
  output logic                      S_AXIS_tready,
  output logic                      send_valid,
  output logic [RAW_DATA_WIDTH-1:0] send_data,
  output logic [1:0]                send_size,
  input  logic                      send_ready,
  output logic [FRAMES_W-1:0]       frames_sent
);

  localparam int NL = RAW_DATA_WIDTH / LANE_WIDTH;

  logic                             live_q;
  logic                             closed_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [NL-1:0][LANE_WIDTH-1:0]    fill_q;
  logic                             out_v_q;
  logic [RAW_DATA_WIDTH-1:0]        out_d_q;
  logic [1:0]                       out_s_q;
  logic [FRAMES_W-1:0]              frames_q;

  logic                             accept;
  logic                             close_now;
  logic                             rel;
  logic                             move;
  logic                             expire;
  logic                             tmr_en;
  logic [CNT_W-1:0]                 cnt_n;
  logic [NL-1:0][LANE_WIDTH-1:0]    fill_n;

  assign S_AXIS_tready = live_q & ~closed_q;
  assign accept        = S_AXIS_tvalid & S_AXIS_tready;
  assign tmr_en        = S_AXIS_tready & (cnt_q != '0) & ~accept;
  assign rel           = out_v_q & send_ready;

  assign close_now = (accept &
                      (S_AXIS_tlast | cnt_q == CNT_W'(NL - 1)))
                   | expire;

  // A slot closing this cycle may move straight out, so the
  // output slot sees the word including the closing beat.
  assign move = (close_now | closed_q) & (~out_v_q | rel);

  always_comb begin
    fill_n = fill_q;
    cnt_n  = cnt_q + CNT_W'(accept);
    if (accept)
      fill_n[cnt_q[LANE_IDX_W-1:0]] = S_AXIS_tdata;
  end

  eth_flush_timer #(
    .TIMEOUT (FLUSH_TIMEOUT)
  ) u_timer (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .clr     (~tmr_en),
    .en      (tmr_en),
    .expire  (expire)
  );

  // Fill slot is zeroed on every move, so lanes never written
  // in the next word are already zero when it leaves.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      live_q   <= 1'b0;
      closed_q <= 1'b0;
      cnt_q    <= '0;
      fill_q   <= '0;
    end else begin
      live_q <= 1'b1;
      if (move) begin
        closed_q <= 1'b0;
        cnt_q    <= '0;
        fill_q   <= '0;
      end else begin
        closed_q <= closed_q | close_now;
        cnt_q    <= cnt_n;
        fill_q   <= fill_n;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      out_v_q  <= 1'b0;
      out_d_q  <= '0;
      out_s_q  <= SEND_SIZE_8B;
      frames_q <= '0;
    end else begin
      if (move) begin
        out_v_q <= 1'b1;
        out_d_q <= fill_n;
        out_s_q <= lanes_to_size(cnt_n);
      end else if (rel) begin
        out_v_q <= 1'b0;
      end
      if (rel)
        frames_q <= frames_q + 1'b1;
    end
  end

  assign send_valid  = out_v_q;
  assign send_data   = out_d_q;
  assign send_size   = out_s_q;
  assign frames_sent = frames_q;

endmodule
